forward_unit_mp: RTL and testbench

Parametrised operand forwarding and hazard unit for the decode/execute boundary of the pipelined RV32I core. It resolves every source operand from one of four places: the EX/MEM result, the MEM/WB writeback value, a small history of recently retired writes, or the regfile value latched at decode. The history covers writes that retired while a consumer was held in decode. The unit also raises the load-use stall and keeps saturating performance counters.

---
 rtl/forward_unit_mp_pkg.sv | 20 ++
 rtl/forward_unit_mp_hist.sv | 77 +++++++
 rtl/forward_unit_mp.sv | 129 ++++++++++++
 tb/tb_forward_unit_mp.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/forward_unit_mp_pkg.sv
// forwardermux: shared types and constants for the operand forwarding unit.
//   fwd_sel_t : per-operand source code reported on fwd_sel
//   CNT_MAX   : saturation value of the performance counters
//   sat_inc   : saturating increment used by both counters
package forwardermux;

  typedef enum logic [1:0] {
    FWD_RF   = 2'd0,
    FWD_EX   = 2'd1,
    FWD_MEM  = 2'd2,
    FWD_HIST = 2'd3
  } fwd_sel_t;

  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == CNT_MAX) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/forward_unit_mp_hist.sv
// fwd_hist_buf: shift register of recently retired regfile writes.
// Entry 0 is the newest. Each lookup port returns the newest entry
// whose rd matches its index.
//   clk, rst      : clock, asynchronous active-high reset (clears all entries)
//   push_en_i     : shift a new retirement in at entry 0
//   push_rd_i     : destination register of the retiring write
//   push_data_i   : value written
//   lookup_reg_i  : NUM_SRC packed register indices to look up
//   hit_o         : per-port match flag
//   data_o        : per-port data of the newest matching entry
module fwd_hist_buf #(
  parameter int XLEN       = 32,
  parameter int REG_AW     = 5,
  parameter int HIST_DEPTH = 2,
  parameter int NUM_SRC    = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push_en_i,
  input  logic [REG_AW-1:0]         push_rd_i,
  input  logic [XLEN-1:0]           push_data_i,
  input  logic [NUM_SRC*REG_AW-1:0] lookup_reg_i,
  output logic [NUM_SRC-1:0]        hit_o,
  output logic [NUM_SRC*XLEN-1:0]   data_o
);

  logic              valid_q [HIST_DEPTH];
  logic [REG_AW-1:0] rd_q    [HIST_DEPTH];
  logic [XLEN-1:0]   data_q  [HIST_DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < HIST_DEPTH; k++) begin
        valid_q[k] <= 1'b0;
        rd_q[k]    <= '0;
        data_q[k]  <= '0;
      end
    end else if (push_en_i) begin
      valid_q[0] <= 1'b1;
      rd_q[0]    <= push_rd_i;
      data_q[0]  <= push_data_i;
      for (int k = 1; k < HIST_DEPTH; k++) begin
        valid_q[k] <= valid_q[k-1];
        rd_q[k]    <= rd_q[k-1];
        data_q[k]  <= data_q[k-1];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_lookup
      logic [REG_AW-1:0] lk_reg;
      logic              port_hit;
      logic [XLEN-1:0]   port_data;

      assign lk_reg = lookup_reg_i[gi*REG_AW +: REG_AW];

      // Scan oldest to newest so the newest matching entry overwrites
      // any older duplicate of the same rd.
      always_comb begin
        port_hit  = 1'b0;
        port_data = '0;
        for (int k = HIST_DEPTH - 1; k >= 0; k--) begin
          if (valid_q[k] && (rd_q[k] == lk_reg) && (lk_reg != '0)) begin
            port_hit  = 1'b1;
            port_data = data_q[k];
          end
        end
      end

      assign hit_o[gi]                = port_hit;
      assign data_o[gi*XLEN +: XLEN]  = port_data;
    end
  endgenerate

endmodule

// File: rtl/forward_unit_mp.sv
// forward_unit_mp: operand forwarding and load-use hazard unit at the
// decode/execute boundary. Each source operand is resolved, newest first,
// from EX/MEM, MEM/WB, the retired-write history, or the regfile value.
//   clk, rst        : clock, asynchronous active-high reset
//   stall_in        : pipeline freeze; history and counters hold
//   src_reg/src_data: per-port source indices and regfile values
//   em_*            : EX/MEM candidate (valid, wr_en, is_load, rd, data)
//   mw_*            : MEM/WB candidate (valid, wr_en, rd, data)
//   fwd_data/fwd_sel: resolved operands and their source codes
//   load_use_stall  : consumer needs a load still in EX/MEM
//   cnt_fwd, cnt_lu : saturating performance counters
module forward_unit_mp
  import forwardermux::*;
#(
  parameter int NUM_SRC    = 2,
  parameter int XLEN       = 32,
  parameter int REG_AW     = 5,
  parameter int HIST_DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      stall_in,
  input  logic [NUM_SRC*REG_AW-1:0] src_reg,
  input  logic [NUM_SRC*XLEN-1:0]   src_data,
  input  logic                      em_valid,
  input  logic                      em_wr_en,
  input  logic                      em_is_load,
  input  logic [REG_AW-1:0]         em_rd,
  input  logic [XLEN-1:0]           em_data,
  input  logic                      mw_valid,
  input  logic                      mw_wr_en,
  input  logic [REG_AW-1:0]         mw_rd,
  input  logic [XLEN-1:0]           mw_data,
  output logic [NUM_SRC*XLEN-1:0]   fwd_data,
  output logic [NUM_SRC*2-1:0]      fwd_sel,
  output logic                      load_use_stall,
  output logic [31:0]               cnt_fwd,
  output logic [31:0]               cnt_lu
);

  logic                    mw_eligible;
  logic [NUM_SRC-1:0]      hist_hit;
  logic [NUM_SRC*XLEN-1:0] hist_data;
  logic [NUM_SRC-1:0]      port_lu;
  logic [NUM_SRC-1:0]      port_fwd;
  logic [31:0]             cnt_fwd_q, cnt_fwd_d;
  logic [31:0]             cnt_lu_q, cnt_lu_d;

  // x0 writes are never recorded; they can never be forwarded anyway.
  assign mw_eligible = mw_valid && mw_wr_en && (mw_rd != '0);

  fwd_hist_buf #(
    .XLEN      (XLEN),
    .REG_AW    (REG_AW),
    .HIST_DEPTH(HIST_DEPTH),
    .NUM_SRC   (NUM_SRC)
  ) u_hist (
    .clk         (clk),
    .rst         (rst),
    .push_en_i   (mw_eligible && !stall_in),
    .push_rd_i   (mw_rd),
    .push_data_i (mw_data),
    .lookup_reg_i(src_reg),
    .hit_o       (hist_hit),
    .data_o      (hist_data)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_port
      logic [REG_AW-1:0] s_reg;
      logic              em_match;
      logic              mw_match;
      fwd_sel_t          port_sel;
      logic [XLEN-1:0]   port_data;

      assign s_reg    = src_reg[gi*REG_AW +: REG_AW];
      assign em_match = em_valid && em_wr_en && (em_rd != '0) && (em_rd == s_reg);
      assign mw_match = mw_eligible && (mw_rd == s_reg);

      always_comb begin
        port_sel  = FWD_RF;
        port_data = src_data[gi*XLEN +: XLEN];
        if (!rst) begin
          if (em_match) begin
            port_sel  = FWD_EX;
            port_data = em_data;
          end else if (mw_match) begin
            port_sel  = FWD_MEM;
            port_data = mw_data;
          end else if (hist_hit[gi]) begin
            port_sel  = FWD_HIST;
            port_data = hist_data[gi*XLEN +: XLEN];
          end
        end
      end

      assign fwd_data[gi*XLEN +: XLEN] = port_data;
      assign fwd_sel[gi*2 +: 2]        = port_sel;
      assign port_lu[gi]               = em_match && em_is_load && !rst;
      assign port_fwd[gi]              = (port_sel != FWD_RF);
    end
  endgenerate

  assign load_use_stall = |port_lu;

  always_comb begin
    cnt_fwd_d = cnt_fwd_q;
    cnt_lu_d  = cnt_lu_q;
    if (!stall_in) begin
      if (|port_fwd)      cnt_fwd_d = sat_inc(cnt_fwd_q);
      if (load_use_stall) cnt_lu_d  = sat_inc(cnt_lu_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_fwd_q <= '0;
      cnt_lu_q  <= '0;
    end else begin
      cnt_fwd_q <= cnt_fwd_d;
      cnt_lu_q  <= cnt_lu_d;
    end
  end

  assign cnt_fwd = cnt_fwd_q;
  assign cnt_lu  = cnt_lu_q;

endmodule

// File: tb/tb_forward_unit_mp.sv
module tb_forward_unit_mp;
  import forwardermux::*;

  localparam int NS = 2;
  localparam int XL = 32;
  localparam int RA = 5;
  localparam int HD = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           stall_in;
  logic [NS*RA-1:0] src_reg;
  logic [NS*XL-1:0] src_data;
  logic           em_valid, em_wr_en, em_is_load;
  logic [RA-1:0]  em_rd;
  logic [XL-1:0]  em_data;
  logic           mw_valid, mw_wr_en;
  logic [RA-1:0]  mw_rd;
  logic [XL-1:0]  mw_data;
  logic [NS*XL-1:0] fwd_data;
  logic [NS*2-1:0]  fwd_sel;
  logic           load_use_stall;
  logic [31:0]    cnt_fwd, cnt_lu;

  forward_unit_mp #(.NUM_SRC(NS), .XLEN(XL), .REG_AW(RA), .HIST_DEPTH(HD)) dut (
    .clk(clk), .rst(rst), .stall_in(stall_in),
    .src_reg(src_reg), .src_data(src_data),
    .em_valid(em_valid), .em_wr_en(em_wr_en), .em_is_load(em_is_load),
    .em_rd(em_rd), .em_data(em_data),
    .mw_valid(mw_valid), .mw_wr_en(mw_wr_en), .mw_rd(mw_rd), .mw_data(mw_data),
    .fwd_data(fwd_data), .fwd_sel(fwd_sel), .load_use_stall(load_use_stall),
    .cnt_fwd(cnt_fwd), .cnt_lu(cnt_lu)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: list of retired writes, newest first, plus counters.
  typedef struct { logic [RA-1:0] rd; logic [XL-1:0] data; } hent_t;
  hent_t       m_hist[$];
  logic [31:0] m_cnt_fwd, m_cnt_lu;
  logic [XL-1:0] exp_data [NS];
  logic [1:0]  exp_sel [NS];
  logic        exp_lu;

  function automatic void model_clear();
    m_hist.delete();
    m_cnt_fwd = 32'd0;
    m_cnt_lu  = 32'd0;
  endfunction

  function automatic void model_eval();
    logic [RA-1:0] r;
    logic found;
    exp_lu = 1'b0;
    for (int p = 0; p < NS; p++) begin
      r = src_reg[p*RA +: RA];
      exp_sel[p]  = FWD_RF;
      exp_data[p] = src_data[p*XL +: XL];
      if (!rst && r != 0) begin
        if (em_valid && em_wr_en && em_rd == r) begin
          exp_sel[p]  = FWD_EX;
          exp_data[p] = em_data;
          if (em_is_load) exp_lu = 1'b1;
        end else if (mw_valid && mw_wr_en && mw_rd == r) begin
          exp_sel[p]  = FWD_MEM;
          exp_data[p] = mw_data;
        end else begin
          found = 1'b0;
          for (int k = 0; k < m_hist.size(); k++) begin
            if (!found && m_hist[k].rd == r) begin
              found       = 1'b1;
              exp_sel[p]  = FWD_HIST;
              exp_data[p] = m_hist[k].data;
            end
          end
        end
      end
    end
  endfunction

  // Advance the model by one clock edge, then the DUT.
  task automatic step();
    hent_t e;
    logic any;
    model_eval();
    if (!rst && !stall_in) begin
      any = 1'b0;
      for (int p = 0; p < NS; p++) if (exp_sel[p] != FWD_RF) any = 1'b1;
      if (any && m_cnt_fwd != 32'hFFFF_FFFF) m_cnt_fwd = m_cnt_fwd + 32'd1;
      if (exp_lu && m_cnt_lu != 32'hFFFF_FFFF) m_cnt_lu = m_cnt_lu + 32'd1;
      if (mw_valid && mw_wr_en && mw_rd != 0) begin
        e.rd = mw_rd;
        e.data = mw_data;
        m_hist.push_front(e);
        if (m_hist.size() > HD) void'(m_hist.pop_back());
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall_in = 1'b0;
    em_valid = 1'b0; em_wr_en = 1'b0; em_is_load = 1'b0; em_rd = '0; em_data = '0;
    mw_valid = 1'b0; mw_wr_en = 1'b0; mw_rd = '0; mw_data = '0;
    src_reg = '0; src_data = '0;
  endtask

  task automatic set_src(input int p, input logic [RA-1:0] r, input logic [XL-1:0] d);
    src_reg[p*RA +: RA]  = r;
    src_data[p*XL +: XL] = d;
  endtask

  task automatic set_em(input logic [RA-1:0] r, input logic [XL-1:0] d, input logic ld);
    em_valid = 1'b1; em_wr_en = 1'b1; em_rd = r; em_data = d; em_is_load = ld;
  endtask

  task automatic set_mw(input logic [RA-1:0] r, input logic [XL-1:0] d);
    mw_valid = 1'b1; mw_wr_en = 1'b1; mw_rd = r; mw_data = d;
  endtask

  function automatic logic [XL-1:0] gd(input int p);
    return fwd_data[p*XL +: XL];
  endfunction

  function automatic logic [1:0] gs(input int p);
    return fwd_sel[p*2 +: 2];
  endfunction

  task automatic test_reset();
    idle();
    rst = 1'b1;
    set_em(5'd1, 32'hCAFE, 1'b1);
    set_src(0, 5'd1, $urandom);
    set_src(1, 5'd1, $urandom);
    #2;
    for (int p = 0; p < NS; p++) begin
      n_cmp++; if (gs(p) !== FWD_RF) begin n_bad++; $display("FAIL reset_sel%0d: got %0d want %0d", p, gs(p), FWD_RF); end
      n_cmp++; if (gd(p) !== src_data[p*XL +: XL]) begin n_bad++; $display("FAIL reset_data%0d: got %h want %h", p, gd(p), src_data[p*XL +: XL]); end
    end
    n_cmp++; if (load_use_stall !== 1'b0) begin n_bad++; $display("FAIL reset_lu: got %b want 0", load_use_stall); end
    @(posedge clk); #1;
    n_cmp++; if (cnt_fwd !== 32'd0) begin n_bad++; $display("FAIL reset_cnt_fwd: got %h want 0", cnt_fwd); end
    n_cmp++; if (cnt_lu !== 32'd0) begin n_bad++; $display("FAIL reset_cnt_lu: got %h want 0", cnt_lu); end
    rst = 1'b0;
    model_clear();
    idle();
    $display("test_reset done");
  endtask

  task automatic test_ex_fwd();
    idle();
    set_em(5'd1, 32'h11, 1'b0);
    set_src(0, 5'd1, 32'h0);
    #1;
    n_cmp++; if (gd(0) !== 32'h11) begin n_bad++; $display("FAIL ex_data: got %h want 11", gd(0)); end
    n_cmp++; if (gs(0) !== FWD_EX) begin n_bad++; $display("FAIL ex_sel: got %0d want %0d", gs(0), FWD_EX); end
    step();
    n_cmp++; if (cnt_fwd !== m_cnt_fwd) begin n_bad++; $display("FAIL ex_cnt_fwd: got %h want %h", cnt_fwd, m_cnt_fwd); end
    idle();
    $display("test_ex_fwd done cnt_fwd=%0d", cnt_fwd);
  endtask

  task automatic test_priority();
    idle();
    set_em(5'd2, 32'hAA, 1'b0);
    set_mw(5'd2, 32'hBB);
    set_src(0, 5'd2, 32'h5);
    #1;
    n_cmp++; if (gd(0) !== 32'hAA) begin n_bad++; $display("FAIL prio_ex_data: got %h want aa", gd(0)); end
    n_cmp++; if (gs(0) !== FWD_EX) begin n_bad++; $display("FAIL prio_ex_sel: got %0d want %0d", gs(0), FWD_EX); end
    em_rd = 5'd0; mw_rd = 5'd0;
    set_src(0, 5'd0, 32'h0);
    #1;
    n_cmp++; if (gd(0) !== 32'h0) begin n_bad++; $display("FAIL prio_x0_data: got %h want 0", gd(0)); end
    n_cmp++; if (gs(0) !== FWD_RF) begin n_bad++; $display("FAIL prio_x0_sel: got %0d want %0d", gs(0), FWD_RF); end
    idle();
    set_mw(5'd9, 32'h55);
    set_src(0, 5'd9, 32'h0);
    step();
    mw_data = 32'h66;
    #1;
    n_cmp++; if (gd(0) !== 32'h66) begin n_bad++; $display("FAIL prio_mem_data: got %h want 66", gd(0)); end
    n_cmp++; if (gs(0) !== FWD_MEM) begin n_bad++; $display("FAIL prio_mem_sel: got %0d want %0d", gs(0), FWD_MEM); end
    step();
    mw_valid = 1'b0;
    #1;
    n_cmp++; if (gd(0) !== 32'h66) begin n_bad++; $display("FAIL prio_hist_data: got %h want 66", gd(0)); end
    n_cmp++; if (gs(0) !== FWD_HIST) begin n_bad++; $display("FAIL prio_hist_sel: got %0d want %0d", gs(0), FWD_HIST); end
    idle();
    $display("test_priority done");
  endtask

  task automatic test_load_use();
    idle();
    set_em(5'd3, 32'h1234, 1'b1);
    set_src(1, 5'd3, 32'h777);
    #1;
    n_cmp++; if (load_use_stall !== 1'b1) begin n_bad++; $display("FAIL lu_stall: got %b want 1", load_use_stall); end
    n_cmp++; if (gs(1) !== FWD_EX) begin n_bad++; $display("FAIL lu_sel: got %0d want %0d", gs(1), FWD_EX); end
    step();
    em_valid = 1'b0;
    set_mw(5'd3, 32'hDEAD);
    #1;
    n_cmp++; if (load_use_stall !== 1'b0) begin n_bad++; $display("FAIL lu_release: got %b want 0", load_use_stall); end
    n_cmp++; if (gd(1) !== 32'hDEAD) begin n_bad++; $display("FAIL lu_mem_data: got %h want dead", gd(1)); end
    n_cmp++; if (gs(1) !== FWD_MEM) begin n_bad++; $display("FAIL lu_mem_sel: got %0d want %0d", gs(1), FWD_MEM); end
    n_cmp++; if (cnt_lu !== 32'd1) begin n_bad++; $display("FAIL lu_cnt: got %h want 1", cnt_lu); end
    step();
    idle();
    $display("test_load_use done cnt_lu=%0d", cnt_lu);
  endtask

  task automatic test_history();
    idle();
    set_src(0, 5'd4, 32'h0);
    set_mw(5'd4, 32'h1); step();
    set_mw(5'd4, 32'h2); step();
    mw_valid = 1'b0;
    #1;
    n_cmp++; if (gd(0) !== 32'h2) begin n_bad++; $display("FAIL hist_newest_data: got %h want 2", gd(0)); end
    n_cmp++; if (gs(0) !== FWD_HIST) begin n_bad++; $display("FAIL hist_newest_sel: got %0d want %0d", gs(0), FWD_HIST); end
    set_mw(5'd5, 32'h5); step();
    mw_valid = 1'b0;
    #1;
    n_cmp++; if (gd(0) !== 32'h2) begin n_bad++; $display("FAIL hist_keep_data: got %h want 2", gd(0)); end
    set_mw(5'd6, 32'h6); step();
    mw_valid = 1'b0;
    #1;
    n_cmp++; if (gd(0) !== 32'h0) begin n_bad++; $display("FAIL hist_drop_data: got %h want 0", gd(0)); end
    n_cmp++; if (gs(0) !== FWD_RF) begin n_bad++; $display("FAIL hist_drop_sel: got %0d want %0d", gs(0), FWD_RF); end
    idle();
    $display("test_history done");
  endtask

  task automatic test_stall_hold();
    idle();
    stall_in = 1'b1;
    set_em(5'd1, 32'h1, 1'b1);
    set_mw(5'd7, 32'h77);
    set_src(0, 5'd7, 32'h3);
    set_src(1, 5'd1, 32'h0);
    #1;
    n_cmp++; if (gs(0) !== FWD_MEM) begin n_bad++; $display("FAIL stall_sel: got %0d want %0d", gs(0), FWD_MEM); end
    step();
    stall_in = 1'b0; em_valid = 1'b0; mw_valid = 1'b0;
    #1;
    n_cmp++; if (gd(0) !== 32'h3) begin n_bad++; $display("FAIL stall_hist_data: got %h want 3", gd(0)); end
    n_cmp++; if (gs(0) !== FWD_RF) begin n_bad++; $display("FAIL stall_hist_sel: got %0d want %0d", gs(0), FWD_RF); end
    n_cmp++; if (cnt_fwd !== m_cnt_fwd) begin n_bad++; $display("FAIL stall_cnt_fwd: got %h want %h", cnt_fwd, m_cnt_fwd); end
    n_cmp++; if (cnt_lu !== m_cnt_lu) begin n_bad++; $display("FAIL stall_cnt_lu: got %h want %h", cnt_lu, m_cnt_lu); end
    idle();
    $display("test_stall_hold done");
  endtask

  task automatic test_random();
    for (int t = 0; t < 250; t++) begin
      stall_in   = ($urandom_range(0, 4) == 0);
      em_valid   = $urandom_range(0, 1);
      em_wr_en   = ($urandom_range(0, 3) != 0);
      em_is_load = ($urandom_range(0, 3) == 0);
      em_rd      = $urandom_range(0, 7);
      em_data    = $urandom;
      mw_valid   = $urandom_range(0, 1);
      mw_wr_en   = ($urandom_range(0, 3) != 0);
      mw_rd      = $urandom_range(0, 7);
      mw_data    = $urandom;
      for (int p = 0; p < NS; p++) set_src(p, $urandom_range(0, 7), $urandom);
      #1;
      model_eval();
      for (int p = 0; p < NS; p++) begin
        n_cmp++; if (gd(p) !== exp_data[p]) begin n_bad++; $display("FAIL rnd_data%0d t=%0d: got %h want %h", p, t, gd(p), exp_data[p]); end
        n_cmp++; if (gs(p) !== exp_sel[p]) begin n_bad++; $display("FAIL rnd_sel%0d t=%0d: got %0d want %0d", p, t, gs(p), exp_sel[p]); end
      end
      n_cmp++; if (load_use_stall !== exp_lu) begin n_bad++; $display("FAIL rnd_lu t=%0d: got %b want %b", t, load_use_stall, exp_lu); end
      $display("txn %0d stall=%b src=%0d,%0d sel=%0d,%0d lu=%b", t, stall_in,
               src_reg[RA-1:0], src_reg[2*RA-1:RA], gs(0), gs(1), load_use_stall);
      step();
      n_cmp++; if (cnt_fwd !== m_cnt_fwd) begin n_bad++; $display("FAIL rnd_cnt_fwd t=%0d: got %h want %h", t, cnt_fwd, m_cnt_fwd); end
      n_cmp++; if (cnt_lu !== m_cnt_lu) begin n_bad++; $display("FAIL rnd_cnt_lu t=%0d: got %h want %h", t, cnt_lu, m_cnt_lu); end
    end
    idle();
    $display("test_random done");
  endtask

  task automatic test_saturation();
    idle();
    force dut.cnt_lu_q = 32'hFFFF_FFFE;
    #1;
    release dut.cnt_lu_q;
    m_cnt_lu = 32'hFFFF_FFFE;
    set_em(5'd3, 32'h9, 1'b1);
    set_src(0, 5'd3, 32'h0);
    for (int k = 0; k < 3; k++) begin
      step();
      n_cmp++; if (cnt_lu !== m_cnt_lu) begin n_bad++; $display("FAIL sat_cnt_lu k=%0d: got %h want %h", k, cnt_lu, m_cnt_lu); end
    end
    n_cmp++; if (cnt_lu !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL sat_final: got %h want ffffffff", cnt_lu); end
    idle();
    $display("test_saturation done cnt_lu=%h", cnt_lu);
  endtask

  task automatic test_reset_midrun();
    idle();
    set_mw(5'd8, 32'h88);
    step();
    mw_valid = 1'b0;
    set_em(5'd8, 32'h99, 1'b1);
    set_src(0, 5'd8, 32'h123);
    set_src(1, 5'd8, 32'h456);
    #2;
    rst = 1'b1;
    #1;
    for (int p = 0; p < NS; p++) begin
      n_cmp++; if (gs(p) !== FWD_RF) begin n_bad++; $display("FAIL mid_rst_sel%0d: got %0d want %0d", p, gs(p), FWD_RF); end
      n_cmp++; if (gd(p) !== src_data[p*XL +: XL]) begin n_bad++; $display("FAIL mid_rst_data%0d: got %h want %h", p, gd(p), src_data[p*XL +: XL]); end
    end
    n_cmp++; if (load_use_stall !== 1'b0) begin n_bad++; $display("FAIL mid_rst_lu: got %b want 0", load_use_stall); end
    n_cmp++; if (cnt_fwd !== 32'd0) begin n_bad++; $display("FAIL mid_rst_cnt_fwd: got %h want 0", cnt_fwd); end
    n_cmp++; if (cnt_lu !== 32'd0) begin n_bad++; $display("FAIL mid_rst_cnt_lu: got %h want 0", cnt_lu); end
    model_clear();
    rst = 1'b0;
    em_valid = 1'b0;
    #1;
    n_cmp++; if (gd(0) !== 32'h123) begin n_bad++; $display("FAIL mid_rst_hist_data: got %h want 123", gd(0)); end
    n_cmp++; if (gs(0) !== FWD_RF) begin n_bad++; $display("FAIL mid_rst_hist_sel: got %0d want %0d", gs(0), FWD_RF); end
    step();
    idle();
    $display("test_reset_midrun done");
  endtask

  initial begin
    model_clear();
    test_reset();
    test_ex_fwd();
    test_priority();
    test_load_use();
    test_history();
    test_stall_hold();
    test_random();
    test_saturation();
    test_reset_midrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
